// File: rtl/branch_commit_tracker_if.sv
// ---------------------------------------------------------------------------
// branch_commit_tracker_if
//   Bundles the dispatch, BCU-result, ROB-head/commit and flush/update signals
//   exchanged between the ROB side and branch_commit_tracker.
//   master : ROB/dispatch/BCU side (drives alloc_*, bcu_*, head_rob_id,
//            commit_valid; observes the tracker outputs)
//   slave  : branch_commit_tracker itself
// ---------------------------------------------------------------------------
interface branch_commit_tracker_if #(
  parameter int ROB_WIDTH = 4,
  parameter int CNT_WIDTH = 32
);
  // Dispatch-side allocation
  logic                 alloc_valid;
  logic [ROB_WIDTH-1:0] alloc_rob_id;
  logic                 alloc_pred_taken;
  // BCU result (id 0 = no result)
  logic [ROB_WIDTH-1:0] bcu_rob_id;
  logic                 bcu_taken;
  logic [31:0]          bcu_value;
  // ROB head / commit
  logic [ROB_WIDTH-1:0] head_rob_id;
  logic                 head_ready;
  logic                 commit_valid;
  // Flush / predictor update / counters
  logic                 flush_out;
  logic [31:0]          redirect_pc;
  logic                 upd_valid;
  logic                 upd_taken;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output alloc_valid, alloc_rob_id, alloc_pred_taken,
    output bcu_rob_id, bcu_taken, bcu_value,
    output head_rob_id, commit_valid,
    input  head_ready, flush_out, redirect_pc, upd_valid, upd_taken,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  alloc_valid, alloc_rob_id, alloc_pred_taken,
    input  bcu_rob_id, bcu_taken, bcu_value,
    input  head_rob_id, commit_valid,
    output head_ready, flush_out, redirect_pc, upd_valid, upd_taken,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_commit_tracker.sv
// ---------------------------------------------------------------------------
// branch_commit_tracker
//   ROB-side receiver of branch results. One entry per ROB index holds the
//   predicted direction and, once the BCU reports, the actual direction and
//   resolved next PC. When the ROB commits a resolved branch at its head the
//   tracker pulses a predictor update, bumps the branch counter and, on a
//   direction mismatch, pulses a flush with the redirect PC.
//
// Ports
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   bif     : branch_commit_tracker_if.slave
//             in : alloc_valid/alloc_rob_id/alloc_pred_taken,
//                  bcu_rob_id/bcu_taken/bcu_value, head_rob_id, commit_valid
//             out: head_ready (comb), flush_out, redirect_pc, upd_valid,
//                  upd_taken, branch_count, mispredict_count (registered)
// ---------------------------------------------------------------------------
module branch_commit_tracker #(
  parameter int ROB_WIDTH = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  branch_commit_tracker_if.slave bif
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  // Per-entry state. Entry 0 is only ever reset, so it always reads as idle.
  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] r_resolved;
  logic [DEPTH-1:0] r_pred_taken;
  logic [DEPTH-1:0] r_act_taken;
  logic [31:0]      r_next_pc [DEPTH];

  logic                 r_flush;
  logic [31:0]          r_redirect_pc;
  logic                 r_upd_valid;
  logic                 r_upd_taken;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  logic             w_head_ready;
  logic             w_commit;
  logic             w_alloc;
  logic             w_bcu_ok;
  logic             w_mispredict;
  logic [DEPTH-1:0] w_alloc_hit;
  logic [DEPTH-1:0] w_cap_hit;
  logic [DEPTH-1:0] w_commit_hit;

  // Readiness looks only at registered state: a BCU result arriving this
  // cycle becomes visible to the head one cycle later.
  assign w_head_ready = (bif.head_rob_id != '0) &&
                        r_pending[bif.head_rob_id] &&
                        r_resolved[bif.head_rob_id];

  // Everything presented during the flush cycle is discarded.
  assign w_commit = bif.commit_valid && w_head_ready && !r_flush;
  assign w_alloc  = bif.alloc_valid && (bif.alloc_rob_id != '0) && !r_flush;
  assign w_bcu_ok = (bif.bcu_rob_id != '0) &&
                    r_pending[bif.bcu_rob_id] &&
                    !r_resolved[bif.bcu_rob_id] && !r_flush;

  assign w_mispredict = r_act_taken[bif.head_rob_id] != r_pred_taken[bif.head_rob_id];

  // Per-entry decode of the three write sources.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign w_alloc_hit[gi]  = w_alloc && (bif.alloc_rob_id == ROB_WIDTH'(gi));
      // A same-cycle allocation to this id restarts the entry, so the
      // result that raced it is dropped.
      assign w_cap_hit[gi]    = w_bcu_ok && (bif.bcu_rob_id == ROB_WIDTH'(gi)) &&
                                !w_alloc_hit[gi];
      assign w_commit_hit[gi] = w_commit && (bif.head_rob_id == ROB_WIDTH'(gi));
    end
  endgenerate

  // Entry state update
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pending    <= '0;
      r_resolved   <= '0;
      r_pred_taken <= '0;
      r_act_taken  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_next_pc[i] <= '0;
      end
    end else if (r_flush) begin
      r_pending  <= '0;
      r_resolved <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_alloc_hit[i]) begin
          // Allocation overrides a same-id commit: the committed branch
          // retires and the new one starts fresh.
          r_pending[i]    <= 1'b1;
          r_resolved[i]   <= 1'b0;
          r_pred_taken[i] <= bif.alloc_pred_taken;
        end else begin
          if (w_commit_hit[i]) begin
            r_pending[i]  <= 1'b0;
            r_resolved[i] <= 1'b0;
          end
          // Capture and commit never hit the same id: commit needs the
          // entry resolved, capture needs it unresolved.
          if (w_cap_hit[i]) begin
            r_resolved[i]  <= 1'b1;
            r_act_taken[i] <= bif.bcu_taken;
            r_next_pc[i]   <= bif.bcu_value;
          end
        end
      end
    end
  end

  // Commit outcome: pulses, redirect and counters
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_taken   <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_upd_valid <= w_commit;
      r_flush     <= w_commit && w_mispredict;
      if (w_commit) begin
        r_upd_taken  <= r_act_taken[bif.head_rob_id];
        r_branch_cnt <= r_branch_cnt + 1'b1;
        if (w_mispredict) begin
          r_redirect_pc <= r_next_pc[bif.head_rob_id];
          r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
      end
    end
  end

  assign bif.head_ready       = w_head_ready;
  assign bif.flush_out        = r_flush;
  assign bif.redirect_pc      = r_redirect_pc;
  assign bif.upd_valid        = r_upd_valid;
  assign bif.upd_taken        = r_upd_taken;
  assign bif.branch_count     = r_branch_cnt;
  assign bif.mispredict_count = r_mispred_cnt;

endmodule

// File: tb/tb_branch_commit_tracker.sv
// ---------------------------------------------------------------------------
// tb_branch_commit_tracker
//   Scoreboard bench: each commit pushes the expected update/flush/counter
//   snapshot; a negedge monitor pops and compares when upd_valid appears.
//   Counters are 4 bits wide so wrap-around is reachable.
// ---------------------------------------------------------------------------
module tb_branch_commit_tracker;
  localparam int RW = 4;
  localparam int CW = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  branch_commit_tracker_if #(.ROB_WIDTH(RW), .CNT_WIDTH(CW)) bif ();

  branch_commit_tracker #(.ROB_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bif    (bif)
  );

  typedef struct {
    logic          taken;
    logic          flush;
    logic [31:0]   pc;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] mcnt;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  logic [CW-1:0] exp_bc = '0;
  logic [CW-1:0] exp_mc = '0;
  logic [31:0]   exp_pc = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk_in) begin
    if (mon_en && rst_in) begin
      if (bif.upd_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_upd", 32'(bif.upd_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("upd_taken",   32'(bif.upd_taken), 32'(e.taken));
          check_eq("flush_out",   32'(bif.flush_out), 32'(e.flush));
          check_eq("redirect_pc", bif.redirect_pc,    e.pc);
          check_eq("branch_cnt",  32'(bif.branch_count),     32'(e.bcnt));
          check_eq("mispred_cnt", 32'(bif.mispredict_count), 32'(e.mcnt));
        end
      end else if (bif.flush_out) begin
        check_eq("flush_without_upd", 32'(bif.flush_out), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_alloc(input logic [RW-1:0] id, input logic pred);
    bif.alloc_valid = 1'b1; bif.alloc_rob_id = id; bif.alloc_pred_taken = pred;
    tick();
    bif.alloc_valid = 1'b0; bif.alloc_rob_id = '0;
  endtask

  task automatic do_bcu(input logic [RW-1:0] id, input logic t, input logic [31:0] pc);
    bif.bcu_rob_id = id; bif.bcu_taken = t; bif.bcu_value = pc;
    tick();
    bif.bcu_rob_id = '0;
  endtask

  task automatic probe_ready(input string tag, input logic [RW-1:0] id, input logic exp);
    bif.head_rob_id = id;
    #1;
    check_eq(tag, 32'(bif.head_ready), 32'(exp));
    bif.head_rob_id = '0;
  endtask

  // Commit the head branch; expectation derived from the prediction that
  // was allocated and the outcome the BCU reported.
  task automatic do_commit(input logic [RW-1:0] id, input logic pred, input logic act,
                           input logic [31:0] pc, input bit wait_flush);
    exp_t e;
    bif.head_rob_id = id; bif.commit_valid = 1'b1;
    #1;
    check_eq("commit_head_ready", 32'(bif.head_ready), 32'd1);
    exp_bc = exp_bc + 1'b1;
    if (pred != act) begin
      exp_mc = exp_mc + 1'b1;
      exp_pc = pc;
    end
    e.taken = act; e.flush = (pred != act); e.pc = exp_pc; e.bcnt = exp_bc; e.mcnt = exp_mc;
    exp_q.push_back(e);
    tick();
    bif.commit_valid = 1'b0; bif.head_rob_id = '0;
    if (wait_flush && pred != act) tick();
  endtask

  initial begin
    bif.alloc_valid = 0; bif.alloc_rob_id = '0; bif.alloc_pred_taken = 0;
    bif.bcu_rob_id = '0; bif.bcu_taken = 0; bif.bcu_value = '0;
    bif.head_rob_id = '0; bif.commit_valid = 0;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_flush",   32'(bif.flush_out), 32'd0);
    check_eq("rst_upd",     32'(bif.upd_valid), 32'd0);
    check_eq("rst_bcnt",    32'(bif.branch_count), 32'd0);
    rst_in = 1'b1;

    // ---------------- async reset with flush high ----------------
    do_alloc(4'd1, 1'b0);
    do_alloc(4'd2, 1'b1);
    do_bcu(4'd1, 1'b1, 32'h55);
    bif.head_rob_id = 4'd1; bif.commit_valid = 1'b1;
    tick();
    bif.commit_valid = 1'b0; bif.head_rob_id = '0;
    check_eq("pre_rst_flush", 32'(bif.flush_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check_eq("arst_flush",    32'(bif.flush_out), 32'd0);
    check_eq("arst_redirect", bif.redirect_pc, 32'd0);
    check_eq("arst_upd",      32'(bif.upd_valid), 32'd0);
    check_eq("arst_upd_tk",   32'(bif.upd_taken), 32'd0);
    check_eq("arst_bcnt",     32'(bif.branch_count), 32'd0);
    check_eq("arst_mcnt",     32'(bif.mispredict_count), 32'd0);
    tick(); tick();
    rst_in = 1'b1;
    for (int i = 1; i < 16; i++) probe_ready($sformatf("post_rst_ready%0d", i), RW'(i), 1'b0);
    mon_en = 1'b1;

    // ---------------- correct prediction ----------------
    do_alloc(4'd3, 1'b1);
    do_bcu(4'd3, 1'b1, 32'h100);
    do_commit(4'd3, 1'b1, 1'b1, 32'h100, 1'b1);

    // ---------------- mispredict + flush cycle drops alloc ----------------
    do_alloc(4'd5, 1'b0);
    do_alloc(4'd6, 1'b1);
    do_bcu(4'd5, 1'b1, 32'h2040);
    do_bcu(4'd6, 1'b1, 32'h3000);
    do_commit(4'd5, 1'b0, 1'b1, 32'h2040, 1'b0);
    do_alloc(4'd9, 1'b1);           // presented during the flush cycle
    #4;                              // settle past negedge of the following cycle
    check_eq("post_flush_pulse", 32'(bif.flush_out), 32'd0);
    probe_ready("flushed_ready5", 4'd5, 1'b0);
    probe_ready("flushed_ready6", 4'd6, 1'b0);
    do_bcu(4'd9, 1'b1, 32'h900);    // id 9 not pending, so ignored
    probe_ready("lost_alloc_ready9", 4'd9, 1'b0);

    // ---------------- ordering / ignore ----------------
    do_bcu(4'd7, 1'b1, 32'h777);
    probe_ready("unalloc_ready7", 4'd7, 1'b0);
    bif.alloc_valid = 1'b1; bif.alloc_rob_id = 4'd7; bif.alloc_pred_taken = 1'b0;
    bif.bcu_rob_id = 4'd7; bif.bcu_taken = 1'b1; bif.bcu_value = 32'h7FF;
    tick();
    bif.alloc_valid = 1'b0; bif.alloc_rob_id = '0; bif.bcu_rob_id = '0;
    probe_ready("same_cycle_ready7", 4'd7, 1'b0);
    do_bcu(4'd7, 1'b1, 32'h7AA);
    do_bcu(4'd7, 1'b0, 32'h7BB);    // second result must not overwrite
    do_commit(4'd7, 1'b0, 1'b1, 32'h7AA, 1'b1);

    // ---------------- no bypass ----------------
    do_alloc(4'd2, 1'b0);
    bif.bcu_rob_id = 4'd2; bif.bcu_taken = 1'b0; bif.bcu_value = 32'h200;
    bif.head_rob_id = 4'd2;
    #1;
    check_eq("no_bypass_ready", 32'(bif.head_ready), 32'd0);
    tick();
    bif.bcu_rob_id = '0;
    #1;
    check_eq("next_cycle_ready", 32'(bif.head_ready), 32'd1);
    do_commit(4'd2, 1'b0, 1'b0, 32'h200, 1'b1);

    // ---------------- commit + alloc same id ----------------
    do_alloc(4'd4, 1'b1);
    do_bcu(4'd4, 1'b1, 32'h400);
    bif.alloc_valid = 1'b1; bif.alloc_rob_id = 4'd4; bif.alloc_pred_taken = 1'b1;
    do_commit(4'd4, 1'b1, 1'b1, 32'h400, 1'b1);
    bif.alloc_valid = 1'b0; bif.alloc_rob_id = '0;
    probe_ready("realloc_ready4", 4'd4, 1'b0);
    do_bcu(4'd4, 1'b0, 32'h444);
    do_commit(4'd4, 1'b1, 1'b0, 32'h444, 1'b1);   // new prediction is 1, actual 0

    // ---------------- back-to-back commits ----------------
    do_alloc(4'd10, 1'b0);
    do_alloc(4'd11, 1'b1);
    do_bcu(4'd10, 1'b0, 32'hA00);
    do_bcu(4'd11, 1'b1, 32'hB00);
    do_commit(4'd10, 1'b0, 1'b0, 32'hA00, 1'b1);
    do_commit(4'd11, 1'b1, 1'b1, 32'hB00, 1'b1);

    // ---------------- counter wrap ----------------
    for (int i = 0; i < 17; i++) begin
      logic [RW-1:0] id;
      logic t;
      id = RW'((i % 15) + 1);
      t  = 1'($urandom_range(0, 1));
      do_alloc(id, t);
      do_bcu(id, t, 32'h1000 + 32'(i));
      do_commit(id, t, t, 32'h1000 + 32'(i), 1'b1);
    end

    // commit_valid with nothing ready: no update
    bif.head_rob_id = 4'd12; bif.commit_valid = 1'b1;
    tick();
    bif.commit_valid = 1'b0; bif.head_rob_id = '0;
    @(negedge clk_in);
    check_eq("no_ready_no_upd", 32'(bif.upd_valid), 32'd0);
    check_eq("final_bcnt", 32'(bif.branch_count), 32'(exp_bc));
    check_eq("final_mcnt", 32'(bif.mispredict_count), 32'(exp_mc));
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_commit_tracker.md
Name: branch_commit_tracker

Overview:
- ROB-side receiver of BCU branch results; BCU results go to the ROB only, never to the CDB.
- Allocates one entry per branch ROB index at dispatch and captures the BCU {rob_id, taken, value} result.
- At commit, compares the actual direction with the predicted direction. On mismatch, emits a one-cycle flush with the redirect PC.
- Drives predictor-update pulses and branch/mispredict performance counters.

Parameters:
- ROB_WIDTH, 4, ROB index width. Index 0 means invalid, so usable ids are 1..2^ROB_WIDTH-1.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  dispatch allocates a branch entry this cycle.
- alloc_rob_id  in  ROB_WIDTH  ROB index of the dispatched branch.
- alloc_pred_taken  in  1  predicted direction.
- bcu_rob_id  in  ROB_WIDTH  BCU result id; 0 means no result.
- bcu_taken  in  1  actual direction.
- bcu_value  in  32  resolved next PC.
- head_rob_id  in  ROB_WIDTH  ROB head index, driven when the head is a branch; 0 otherwise.
- head_ready  out  1  combinational: head entry is pending and resolved.
- commit_valid  in  1  ROB commits the head branch this cycle.
- flush_out  out  1  registered pulse: mispredict, flush the pipeline.
- redirect_pc  out  32  registered new fetch PC, valid with flush_out.
- upd_valid  out  1  registered pulse: predictor update.
- upd_taken  out  1  actual direction, valid with upd_valid.
- branch_count  out  CNT_WIDTH  committed branches.
- mispredict_count  out  CNT_WIDTH  committed mispredicts.

Behaviour:
- Per-entry state, indexed by ROB id: pending, resolved, pred_taken, act_taken, next_pc.
- Entry 0 is never written and reads as not pending.
- Reset (rst_in low, async) clears all entries and forces outputs to 0:
  - flush_out, redirect_pc, upd_valid, upd_taken, branch_count, mispredict_count.
- Allocate: alloc_valid && alloc_rob_id!=0 sets pending=1, resolved=0 and stores pred_taken.
- Capture: bcu_rob_id!=0 && pending[bcu_rob_id] && !resolved sets resolved=1 and stores act_taken and next_pc.
  - A result for a non-pending or already-resolved id is ignored.
- Allocate and capture to the same id in the same cycle: allocate wins and the result is dropped.
- head_ready = (head_rob_id!=0) && pending[head_rob_id] && resolved[head_rob_id].
  - Combinational from registered state only; no bypass of a same-cycle BCU result.
- Commit: commit_valid && head_ready && !flush_out. Next cycle:
  - upd_valid=1, upd_taken=act_taken, branch_count+1.
  - If act_taken != pred_taken: additionally flush_out=1, redirect_pc=next_pc, mispredict_count+1.
  - The entry's pending bit is cleared.
- commit_valid without head_ready is ignored; no state change.
- Latency: commit to flush_out/upd_valid is exactly 1 cycle.
  - flush_out and upd_valid are single-cycle pulses and return to 0 next cycle unless another commit occurs.
  - redirect_pc holds its last value when flush_out=0.
- Flush cycle (flush_out=1): all pending and resolved bits clear at the end of that cycle.
  - alloc, capture and commit presented in that cycle are dropped.
  - Counters are not reset by flush.
- Counters wrap modulo 2^CNT_WIDTH.
- Commit and allocate in the same cycle to different ids: both take effect.
- Commit id equal to alloc id in the same cycle: allocate wins, the commit still completes, and the entry is left pending and unresolved.
- Back-to-back commits on consecutive cycles are supported when no flush is pending.

Test Plan:
- Reset mid-run: rst_in low with entries pending and flush_out high → all outputs 0 immediately (async); head_ready=0 for any id after release.
- Correct prediction: alloc id 3 pred 1; BCU {3,1,0x100}; head 3, commit → next cycle upd_valid=1, upd_taken=1, flush_out=0, branch_count=1, mispredict_count=0.
- Mispredict: alloc id 5 pred 0; BCU {5,1,0x2040}; commit → flush_out=1, redirect_pc=0x2040, mispredict_count=1.
  - Following cycle: pulses 0; head_ready=0 for ids 5 and 6; an alloc presented during the flush cycle is lost.
- Ordering/ignore: BCU {7,...} with id 7 not allocated → ignored, head_ready(7)=0.
  - Alloc id 7 and BCU {7} in the same cycle → entry pending, unresolved.
  - A second BCU result for a resolved id does not overwrite next_pc.
- No bypass: BCU {2,...} and head 2 in the same cycle → head_ready=0 that cycle, 1 the next.
- Wrap: CNT_WIDTH=4, commit 17 correct branches → branch_count=1; commit_valid with head_ready=0 → no upd_valid.
